wb_slave_mem_resp: RTL and testbench

- Synthesizable Wishbone classic slave responder with a single-port 32-bit memory, programmable wait states and address-range error signalling.
- Sits directly downstream of the testbench Wishbone master driver. It consumes the adr/dat/sel/we/cyc/stb requests the driver produces and returns ack/err/read data.
- Serves as a stand-in register/buffer-descriptor target for bring-up and as a reference responder for the master driver.

---
 rtl/wb_slave_mem_resp_if.sv | 27 ++
 rtl/wb_slave_mem_resp.sv | 186 ++++++++++++++++++
 tb/tb_wb_slave_mem_resp.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_mem_resp_if.sv
// Wishbone classic bus bundle between the master driver and the
// memory responder; master drives requests, slave returns ack/err/data.
interface wb_slave_mem_resp_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [SEL_WIDTH-1:0]  wb_sel_i;
    logic                  wb_we_i;
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_ack_o;
    logic                  wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_slave_mem_resp.sv
// Wishbone classic slave: single-port word memory, programmable wait states,
// err on out-of-range words. Optional counters under `WB_SLV_STATS_EN.
module wb_slave_mem_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = 4,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_slave_mem_resp_if.slave   bus
`ifdef WB_SLV_STATS_EN
    ,
    input  logic                 stat_clr_i,
    output logic [15:0]          stat_rd_cnt_o,
    output logic [15:0]          stat_wr_cnt_o,
    output logic [15:0]          stat_err_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [3:0] WAIT_LD =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic                  r_we;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat_o;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_go;
    logic [ADDR_WIDTH-1:0] w_adr;
    logic [DATA_WIDTH-1:0] w_dat;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic                  w_we;
    logic                  w_in;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_er;

    assign w_req = bus.wb_cyc_i & bus.wb_stb_i;

    // Pick the request being terminated this edge: live bus with no wait
    // states, otherwise the copy latched when the request was accepted.
    always_comb begin
        w_go  = 1'b0;
        w_adr = r_adr;
        w_dat = r_dat;
        w_sel = r_sel;
        w_we  = r_we;
        if (r_state == S_IDLE && w_req && WAIT_CYCLES == 0) begin
            w_go  = 1'b1;
            w_adr = bus.wb_adr_i;
            w_dat = bus.wb_dat_i;
            w_sel = bus.wb_sel_i;
            w_we  = bus.wb_we_i;
        end else if (r_state == S_WAIT && w_req && r_cnt == 4'd0) begin
            w_go = 1'b1;
        end
    end

    assign w_in  = ({1'b0, w_adr} < DEPTH_L);
    assign w_idx = w_adr[IDX_W-1:0];
    assign w_rd  = w_go & w_in & ~w_we;
    assign w_wr  = w_go & w_in & w_we & wb_rst_i;
    assign w_er  = w_go & ~w_in;

    // Request acceptance, wait countdown, abort and one-cycle termination.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack <= w_go & w_in;
            r_err <= w_er;
            if (w_rd) begin
                r_dat_o <= r_mem[w_idx];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr <= bus.wb_adr_i;
                        r_dat <= bus.wb_dat_i;
                        r_sel <= bus.wb_sel_i;
                        r_we  <= bus.wb_we_i;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= WAIT_LD;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write into the memory array at the termination edge.
    always_ff @(posedge wb_clk_i) begin
        if (w_wr) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_dat[8*i +: 8];
                end
            end
        end
    end

    assign bus.wb_ack_o = r_ack;
    assign bus.wb_err_o = r_err;
    assign bus.wb_dat_o = r_dat_o;

`ifdef WB_SLV_STATS_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;
    logic [15:0] r_err_cnt;
    logic        w_wr_ev;

    assign w_wr_ev = w_go & w_in & w_we;

    // Saturating transfer counters; clear has priority over increment.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_rd_cnt  <= 16'd0;
            r_wr_cnt  <= 16'd0;
            r_err_cnt <= 16'd0;
        end else if (stat_clr_i) begin
            r_rd_cnt  <= 16'd0;
            r_wr_cnt  <= 16'd0;
            r_err_cnt <= 16'd0;
        end else begin
            if (w_rd && r_rd_cnt != 16'hFFFF) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_wr_ev && r_wr_cnt != 16'hFFFF) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_er && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign stat_rd_cnt_o  = r_rd_cnt;
    assign stat_wr_cnt_o  = r_wr_cnt;
    assign stat_err_cnt_o = r_err_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_wb_slave_mem_resp.sv
// Bench for wb_slave_mem_resp: one instance with no wait states and one
// with three, driven by a Wishbone master task and a response scoreboard.
module tb_wb_slave_mem_resp;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_slave_mem_resp_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .SEL_WIDTH(4)) if0 ();
    wb_slave_mem_resp_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .SEL_WIDTH(4)) if3 ();

`ifdef WB_SLV_STATS_EN
    logic        clr0;
    logic        clr3;
    logic [15:0] rd0, wr0, er0, rd3, wr3, er3;
`endif

    wb_slave_mem_resp #(.WAIT_CYCLES(0)) u_dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (if0)
`ifdef WB_SLV_STATS_EN
        ,
        .stat_clr_i     (clr0),
        .stat_rd_cnt_o  (rd0),
        .stat_wr_cnt_o  (wr0),
        .stat_err_cnt_o (er0)
`endif
    );

    wb_slave_mem_resp #(.WAIT_CYCLES(3)) u_dut3 (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (if3)
`ifdef WB_SLV_STATS_EN
        ,
        .stat_clr_i     (clr3),
        .stat_rd_cnt_o  (rd3),
        .stat_wr_cnt_o  (wr3),
        .stat_err_cnt_o (er3)
`endif
    );

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        sbq[$];
    logic [31:0] mdl [2][256];
    logic [31:0] last [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic c, input logic s,
                         input logic we, input logic [9:0] a,
                         input logic [31:0] dt, input logic [3:0] sl);
        if (d == 0) begin
            if0.wb_cyc_i = c; if0.wb_stb_i = s; if0.wb_we_i = we;
            if0.wb_adr_i = a; if0.wb_dat_i = dt; if0.wb_sel_i = sl;
        end else begin
            if3.wb_cyc_i = c; if3.wb_stb_i = s; if3.wb_we_i = we;
            if3.wb_adr_i = a; if3.wb_dat_i = dt; if3.wb_sel_i = sl;
        end
    endtask

    function automatic logic [33:0] obs(input int d);
        if (d == 0) return {if0.wb_ack_o, if0.wb_err_o, if0.wb_dat_o};
        return {if3.wb_ack_o, if3.wb_err_o, if3.wb_dat_o};
    endfunction

    // One full transfer; called #1 after a posedge, returns at the same phase.
    task automatic xfer(input int d, input logic we, input logic [9:0] a,
                        input logic [31:0] dt, input logic [3:0] sl);
        exp_t        e;
        exp_t        x;
        int          lat;
        logic [33:0] o;
        bit          inr;
        inr = (a < 10'd256);
        e.ack = inr;
        e.err = !inr;
        e.dat = last[d];
        if (inr && !we) begin
            e.dat   = mdl[d][a[7:0]];
            last[d] = e.dat;
        end
        if (inr && we) begin
            for (int i = 0; i < 4; i++)
                if (sl[i]) mdl[d][a[7:0]][8*i +: 8] = dt[8*i +: 8];
        end
        sbq.push_back(e);
        drive(d, 1'b1, 1'b1, we, a, dt, sl);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            o = obs(d);
        end while (!(o[33] | o[32]) && lat < 20);
        x = sbq.pop_front();
        if (!(o[33] | o[32])) begin
            chk("timeout", 32'(lat), 32'd0);
        end else begin
            chk("ack", 32'(o[33]), 32'(x.ack));
            chk("err", 32'(o[32]), 32'(x.err));
            chk("dat", o[31:0], x.dat);
            chk("lat", 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        end
        drive(d, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
        @(posedge clk); #1;
        o = obs(d);
        chk("pulse", 32'(o[33:32]), 32'd0);
    endtask

`ifdef WB_SLV_STATS_EN
    task automatic stats_chk(input string tag, input logic [15:0] r,
                             input logic [15:0] w, input logic [15:0] e);
        chk({tag, "_rd"}, 32'(rd0), 32'(r));
        chk({tag, "_wr"}, 32'(wr0), 32'(w));
        chk({tag, "_er"}, 32'(er0), 32'(e));
    endtask

    task automatic clr_pulse();
        clr0 = 1'b1;
        @(posedge clk); #1;
        clr0 = 1'b0;
    endtask
`endif

    initial begin
        bit          seen;
        logic [33:0] o;
        rst_n = 1'b0;
        last[0] = 32'd0;
        last[1] = 32'd0;
`ifdef WB_SLV_STATS_EN
        clr0 = 1'b0;
        clr3 = 1'b0;
`endif
        drive(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", 32'(if0.wb_ack_o), 32'd0);
        chk("rst_err0", 32'(if0.wb_err_o), 32'd0);
        chk("rst_dat0", if0.wb_dat_o, 32'd0);
        chk("rst_ack3", 32'(if3.wb_ack_o), 32'd0);
        chk("rst_err3", 32'(if3.wb_err_o), 32'd0);
        chk("rst_dat3", if3.wb_dat_o, 32'd0);
`ifdef WB_SLV_STATS_EN
        stats_chk("st_rst", 16'd0, 16'd0, 16'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic write/read, byte lanes, out of range, sel=0
        xfer(0, 1'b1, 10'h004, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 10'h004, 32'h0, 4'hF);
        xfer(0, 1'b1, 10'h010, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101);
        xfer(0, 1'b0, 10'h010, 32'h0, 4'h0);
        chk("lanes", mdl[0][8'h10], 32'h11BB33DD);
        xfer(0, 1'b1, 10'h0FF, 32'h5A5A5A5A, 4'hF);
        xfer(0, 1'b0, 10'h100, 32'h0, 4'hF);
        xfer(0, 1'b1, 10'h3FF, 32'h01020304, 4'hF);
        xfer(0, 1'b0, 10'h0FF, 32'h0, 4'hF);
        xfer(0, 1'b1, 10'h004, 32'h00000000, 4'h0);
        xfer(0, 1'b0, 10'h004, 32'h0, 4'hF);

        // back-to-back: stb held through the ack edge
        drive(0, 1'b1, 1'b1, 1'b0, 10'h010, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("b2b_ack1", 32'(if0.wb_ack_o), 32'd1);
        @(posedge clk); #1;
        chk("b2b_gap", 32'(if0.wb_ack_o), 32'd0);
        @(posedge clk); #1;
        chk("b2b_ack2", 32'(if0.wb_ack_o), 32'd1);
        chk("b2b_dat", if0.wb_dat_o, 32'h11BB33DD);
        drive(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
        @(posedge clk); #1;
        last[0] = 32'h11BB33DD;

        // three wait states
        xfer(1, 1'b1, 10'h020, 32'hCAFEF00D, 4'hF);
        xfer(1, 1'b0, 10'h020, 32'h0, 4'hF);
        xfer(1, 1'b0, 10'h200, 32'h0, 4'hF);

        // abort a write after two clocks
        drive(1, 1'b1, 1'b1, 1'b1, 10'h020, 32'h12345678, 4'hF);
        @(posedge clk);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            o = obs(1);
            if (o[33] | o[32]) seen = 1'b1;
        end
        chk("abort_term", 32'(seen), 32'd0);
        xfer(1, 1'b0, 10'h020, 32'h0, 4'hF);

        // reset during the wait phase of a write
        drive(1, 1'b1, 1'b1, 1'b1, 10'h020, 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_3", 32'(obs(1)), 32'd0);
        chk("mrst_3t", 32'(obs(1) >> 32), 32'd0);
        chk("mrst_0", 32'(obs(0)), 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last[0] = 32'd0;
        last[1] = 32'd0;
        @(posedge clk); #1;
        xfer(1, 1'b0, 10'h020, 32'h0, 4'hF);

`ifdef WB_SLV_STATS_EN
        clr_pulse();
        stats_chk("st_clr0", 16'd0, 16'd0, 16'd0);
        xfer(0, 1'b0, 10'h004, 32'h0, 4'hF);
        xfer(0, 1'b0, 10'h010, 32'h0, 4'hF);
        xfer(0, 1'b0, 10'h0FF, 32'h0, 4'hF);
        xfer(0, 1'b1, 10'h030, 32'h0000AAAA, 4'hF);
        xfer(0, 1'b1, 10'h031, 32'h0000BBBB, 4'h3);
        xfer(0, 1'b0, 10'h200, 32'h0, 4'hF);
        stats_chk("st_cnt", 16'd3, 16'd2, 16'd1);
        clr_pulse();
        stats_chk("st_clr1", 16'd0, 16'd0, 16'd0);
`endif

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
